cache_arbiter: RTL and testbench

Sequences the single physical-memory port between the instruction cache and the data cache of the pipelined RV32I core. Both caches issue 256-bit line transactions; the arbiter grants one at a time, holds the grant until the memory's response, and routes that response back to the owner. It sits between the two L1 caches and the cacheline adaptor / physical memory.

---
 rtl/rv32i_types.sv | 19 +
 rtl/cache_arbiter_grant.sv | 28 ++
 rtl/cache_arbiter.sv | 119 +++++++++++
 tb/tb_cache_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I core types: word/line widths plus the memory arbiter state
// encoding and grant select values.
package rv32i_types;

  typedef logic [31:0]  rv32i_word;
  typedef logic [255:0] rv32i_line;

  // Arbiter state encoding, kept as plain constants so older code that
  // compares against raw 2-bit values keeps working.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE    = 2'd0;
  localparam arb_state_t SERVE_I = 2'd1;
  localparam arb_state_t SERVE_D = 2'd2;

  // Grant select: which cache owns the memory port.
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/cache_arbiter_grant.sv
// Grant selection between icache and dcache requests.
// Optional feature macro: CACHE_ARB_ROUND_ROBIN_EN (ties go to the side that
// was not served last). Without it, dcache always wins a tie.
module cache_arbiter_grant
  import rv32i_types::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef CACHE_ARB_ROUND_ROBIN_EN
  input  logic last_grant,
`endif
  output logic any_req,
  output logic grant_d
);

  // Pick the owner for a new transaction; only meaningful when any_req is set.
  always_comb begin
    any_req = i_req | d_req;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    // On a tie, favour icache only if dcache was the most recent owner.
    grant_d = d_req & (~i_req | (last_grant == GRANT_I));
`else
    // Fixed priority: any dcache request beats the icache.
    grant_d = d_req;
`endif
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbiter for the single physical-memory port shared by the L1 icache and
// dcache. One 256-bit line transaction at a time; grant held until pmem_resp.
// Optional feature macro: CACHE_ARB_ROUND_ROBIN_EN (round-robin tie break
// using a last_grant register; otherwise fixed dcache priority).
module cache_arbiter
  import rv32i_types::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_read,
  input  logic [31:0]  i_address,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [31:0]  d_address,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  arb_state_t state_reg;
  arb_state_t state_next;
  rv32i_word  addr_reg;
  rv32i_line  wdata_reg;
  logic       write_reg;

  logic i_req;
  logic d_req;
  logic any_req;
  logic grant_d;
  logic grant_start;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic last_grant_reg;
`endif

  assign i_req = i_read;
  // A simultaneous read+write from the dcache is a writeback.
  assign d_req = d_read | d_write;

  cache_arbiter_grant u_grant (
    .i_req      (i_req),
    .d_req      (d_req),
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    .last_grant (last_grant_reg),
`endif
    .any_req    (any_req),
    .grant_d    (grant_d)
  );

  // A new transaction can only begin from IDLE, which also guarantees one
  // idle cycle between back-to-back transactions.
  assign grant_start = (state_reg == IDLE) && any_req;

  // Next-state logic: grant from IDLE, return to IDLE on memory response.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = grant_d ? SERVE_D : SERVE_I;
      SERVE_I: if (pmem_resp) state_next = IDLE;
      SERVE_D: if (pmem_resp) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and holding registers; the request is captured at the grant edge
  // so later changes on the request lines cannot disturb the transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant_start) begin
        addr_reg  <= grant_d ? d_address : i_address;
        write_reg <= grant_d & d_write;
        if (grant_d) wdata_reg <= d_wdata;
      end
    end
  end

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  // Remember the most recent owner so the next tie goes the other way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_reg <= GRANT_D;
    end else if (grant_start) begin
      last_grant_reg <= grant_d;
    end
  end
`endif

  // Memory-side outputs decode directly from the state so an asynchronous
  // reset drops the strobes immediately.
  always_comb begin
    pmem_read    = (state_reg == SERVE_I) || ((state_reg == SERVE_D) && !write_reg);
    pmem_write   = (state_reg == SERVE_D) && write_reg;
    pmem_address = addr_reg;
    pmem_wdata   = wdata_reg;
  end

  // Response routing: data goes to both caches, only the owner sees resp.
  always_comb begin
    i_rdata = pmem_rdata;
    d_rdata = pmem_rdata;
    i_resp  = (state_reg == SERVE_I) && pmem_resp;
    d_resp  = (state_reg == SERVE_D) && pmem_resp;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed testbench for cache_arbiter. Inputs change 2 time units after
// the rising edge; outputs are checked 1 unit after that.
module tb_cache_arbiter;

  logic         clk;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_address;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_address;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int checks;
  int failures;

  localparam logic [255:0] LINE_AA = {32{8'hAA}};
  localparam logic [255:0] LINE_55 = {32{8'h55}};
  localparam logic [255:0] LINE_C3 = {32{8'hC3}};

  cache_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    step();
    step();
    #1;
    checks++; if (pmem_read !== 1'b0) begin failures++; $display("FAIL reset_pmem_read got=%b exp=0", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL reset_pmem_write got=%b exp=0", pmem_write); end
    checks++; if (i_resp !== 1'b0) begin failures++; $display("FAIL reset_i_resp got=%b exp=0", i_resp); end
    checks++; if (d_resp !== 1'b0) begin failures++; $display("FAIL reset_d_resp got=%b exp=0", d_resp); end
    checks++; if (pmem_address !== 32'h0) begin failures++; $display("FAIL reset_pmem_address got=%h exp=0", pmem_address); end
    checks++; if (pmem_wdata !== 256'h0) begin failures++; $display("FAIL reset_pmem_wdata got=%h exp=0", pmem_wdata); end
    $display("test_reset: outputs idle under reset");
    rst = 1'b0;
    step();
  endtask

  task automatic test_icache_read();
    i_read = 1'b1;
    i_address = 32'h0000_0060;
    #1;
    checks++; if (pmem_read !== 1'b0) begin failures++; $display("FAIL icache_cycle0_strobe got=%b exp=0", pmem_read); end
    step();
    checks++; if (pmem_read !== 1'b1) begin failures++; $display("FAIL icache_cycle1_read got=%b exp=1", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL icache_cycle1_write got=%b exp=0", pmem_write); end
    checks++; if (pmem_address !== 32'h0000_0060) begin failures++; $display("FAIL icache_address got=%h exp=00000060", pmem_address); end
    for (int k = 2; k <= 5; k++) begin
      step();
      checks++; if (pmem_read !== 1'b1 || i_resp !== 1'b0) begin failures++; $display("FAIL icache_wait_c%0d read=%b resp=%b exp read=1 resp=0", k, pmem_read, i_resp); end
    end
    pmem_rdata = LINE_AA;
    pmem_resp = 1'b1;
    #1;
    checks++; if (i_resp !== 1'b1) begin failures++; $display("FAIL icache_i_resp got=%b exp=1", i_resp); end
    checks++; if (i_rdata !== LINE_AA) begin failures++; $display("FAIL icache_i_rdata got=%h exp=%h", i_rdata, LINE_AA); end
    checks++; if (d_resp !== 1'b0) begin failures++; $display("FAIL icache_d_resp got=%b exp=0", d_resp); end
    step();
    pmem_resp = 1'b0;
    i_read = 1'b0;
    #1;
    checks++; if (pmem_read !== 1'b0 || i_resp !== 1'b0) begin failures++; $display("FAIL icache_after_resp read=%b resp=%b exp 0 0", pmem_read, i_resp); end
    $display("test_icache_read: line read at 0x60 with 5-cycle memory");
    step();
  endtask

  task automatic test_tie();
    logic first_d;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_read = 1'b1; i_address = 32'h0000_0080;
    d_write = 1'b1; d_address = 32'h0000_1000; d_wdata = LINE_55;
    step();
    #1;
    if (first_d) begin
      checks++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin failures++; $display("FAIL tie_first_dir write=%b read=%b exp 1 0", pmem_write, pmem_read); end
      checks++; if (pmem_address !== 32'h0000_1000) begin failures++; $display("FAIL tie_first_addr got=%h exp=00001000", pmem_address); end
      checks++; if (pmem_wdata !== LINE_55) begin failures++; $display("FAIL tie_first_wdata got=%h exp=%h", pmem_wdata, LINE_55); end
    end else begin
      checks++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin failures++; $display("FAIL tie_first_dir read=%b write=%b exp 1 0", pmem_read, pmem_write); end
      checks++; if (pmem_address !== 32'h0000_0080) begin failures++; $display("FAIL tie_first_addr got=%h exp=00000080", pmem_address); end
    end
    step();
    step();
    pmem_rdata = LINE_C3;
    pmem_resp = 1'b1;
    #1;
    checks++; if (d_resp !== first_d || i_resp !== !first_d) begin failures++; $display("FAIL tie_first_resp d=%b i=%b exp d=%b i=%b", d_resp, i_resp, first_d, !first_d); end
    step();
    pmem_resp = 1'b0;
    if (first_d) d_write = 1'b0; else i_read = 1'b0;
    #1;
    checks++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin failures++; $display("FAIL tie_gap_strobes read=%b write=%b exp 0 0", pmem_read, pmem_write); end
    step();
    if (first_d) begin
      checks++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0080) begin failures++; $display("FAIL tie_second_strobe read=%b addr=%h exp 1 00000080", pmem_read, pmem_address); end
    end else begin
      checks++; if (pmem_write !== 1'b1 || pmem_address !== 32'h0000_1000) begin failures++; $display("FAIL tie_second_strobe write=%b addr=%h exp 1 00001000", pmem_write, pmem_address); end
    end
    pmem_resp = 1'b1;
    #1;
    checks++; if (i_resp !== first_d || d_resp !== !first_d) begin failures++; $display("FAIL tie_second_resp i=%b d=%b exp i=%b d=%b", i_resp, d_resp, first_d, !first_d); end
    step();
    pmem_resp = 1'b0;
    i_read = 1'b0; d_write = 1'b0;
    #1;
    checks++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin failures++; $display("FAIL tie_end_idle read=%b write=%b exp 0 0", pmem_read, pmem_write); end
    $display("test_tie: simultaneous icache read and dcache write, first_d=%b", first_d);
    step();
  endtask

  task automatic test_addr_stable();
    d_read = 1'b1;
    d_address = 32'h0000_2000;
    step();
    checks++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_2000) begin failures++; $display("FAIL stable_start read=%b addr=%h exp 1 00002000", pmem_read, pmem_address); end
    d_address = 32'hDEAD_BEE0;
    step();
    checks++; if (pmem_address !== 32'h0000_2000) begin failures++; $display("FAIL stable_addr_c2 got=%h exp=00002000", pmem_address); end
    step();
    checks++; if (pmem_address !== 32'h0000_2000) begin failures++; $display("FAIL stable_addr_c3 got=%h exp=00002000", pmem_address); end
    pmem_rdata = LINE_AA;
    pmem_resp = 1'b1;
    #1;
    checks++; if (d_resp !== 1'b1 || d_rdata !== LINE_AA || i_resp !== 1'b0) begin failures++; $display("FAIL stable_resp d_resp=%b i_resp=%b d_rdata=%h exp 1 0 %h", d_resp, i_resp, d_rdata, LINE_AA); end
    step();
    pmem_resp = 1'b0;
    d_read = 1'b0;
    $display("test_addr_stable: dcache read address latched at 0x2000");
    step();
  endtask

  task automatic test_read_write_both();
    d_read = 1'b1;
    d_write = 1'b1;
    d_address = 32'h0000_4040;
    d_wdata = LINE_C3;
    step();
    checks++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin failures++; $display("FAIL rw_both_dir write=%b read=%b exp 1 0", pmem_write, pmem_read); end
    checks++; if (pmem_wdata !== LINE_C3) begin failures++; $display("FAIL rw_both_wdata got=%h exp=%h", pmem_wdata, LINE_C3); end
    pmem_resp = 1'b1;
    #1;
    checks++; if (d_resp !== 1'b1) begin failures++; $display("FAIL rw_both_resp got=%b exp=1", d_resp); end
    step();
    pmem_resp = 1'b0;
    d_read = 1'b0; d_write = 1'b0;
    $display("test_read_write_both: read+write treated as writeback");
    step();
  endtask

  task automatic test_spurious_resp();
    pmem_resp = 1'b1;
    #1;
    checks++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin failures++; $display("FAIL spurious_resp i=%b d=%b exp 0 0", i_resp, d_resp); end
    step();
    checks++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0) begin failures++; $display("FAIL spurious_idle read=%b write=%b i=%b d=%b exp all 0", pmem_read, pmem_write, i_resp, d_resp); end
    pmem_resp = 1'b0;
    $display("test_spurious_resp: pmem_resp in IDLE ignored");
    step();
  endtask

  task automatic test_reset_mid();
    d_write = 1'b1;
    d_address = 32'h0000_3000;
    d_wdata = LINE_55;
    step();
    checks++; if (pmem_write !== 1'b1) begin failures++; $display("FAIL rstmid_before got=%b exp=1", pmem_write); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL rstmid_async_drop got=%b exp=0", pmem_write); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (pmem_write !== 1'b0 || pmem_read !== 1'b0) begin failures++; $display("FAIL rstmid_idle write=%b read=%b exp 0 0", pmem_write, pmem_read); end
    step();
    checks++; if (pmem_write !== 1'b1 || pmem_address !== 32'h0000_3000) begin failures++; $display("FAIL rstmid_regrant write=%b addr=%h exp 1 00003000", pmem_write, pmem_address); end
    pmem_resp = 1'b1;
    #1;
    checks++; if (d_resp !== 1'b1) begin failures++; $display("FAIL rstmid_resp got=%b exp=1", d_resp); end
    step();
    pmem_resp = 1'b0;
    d_write = 1'b0;
    $display("test_reset_mid: reset during writeback, re-granted after release");
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_icache_read();
    test_tie();
    test_addr_stable();
    test_read_write_both();
    test_spurious_resp();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
